// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake, divide-by-zero flag.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division); default build is unsigned.
module seq_restoring_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvsr_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_fin_s;
    logic [WIDTH-1:0] rem_fin_s;
    logic [WIDTH-1:0] a_cap_s;
    logic [WIDTH-1:0] b_cap_s;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        negate = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes captured at accept; MIN maps to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_cap_s = dividend[WIDTH-1] ? negate(dividend) : dividend;
        b_cap_s = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
    end

    // Sign fix-up of the final iteration's result, landing in the DONE cycle.
    always_comb begin
        quo_fin_s = neg_q_r ? negate(quo_nxt_s) : quo_nxt_s;
        rem_fin_s = neg_r_r ? negate(rem_nxt_s) : rem_nxt_s;
    end
`else
    // Unsigned operands pass straight through.
    always_comb begin
        a_cap_s   = dividend;
        b_cap_s   = divisor;
        quo_fin_s = quo_nxt_s;
        rem_fin_s = rem_nxt_s;
    end
`endif

    // One restoring step: shift {R,Q} left and subtract the divisor when it fits.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s  = shift_s[WIDTH-1:0] - dvsr_r;
        if (shift_s >= {1'b0, dvsr_r}) begin
            rem_nxt_s = diff_s;
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, iteration registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            dvsr_r    <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            // No iterations needed; results are defined directly.
                            state_r   <= DONE;
                            done      <= 1'b1;
                            quotient  <= {WIDTH{1'b1}};
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy    <= 1'b1;
                            cnt_r   <= CW'(WIDTH);
                            quo_r   <= a_cap_s;
                            rem_r   <= {WIDTH{1'b0}};
                            dvsr_r  <= b_cap_s;
`ifdef SEQ_DIV_SIGNED_EN
                            neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r_r <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    quo_r <= quo_nxt_s;
                    rem_r <= rem_nxt_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_fin_s;
                        remainder <= rem_fin_s;
                        div_zero  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Table-driven bench for seq_restoring_div plus hand-written handshake, re-start and reset sequences.
module tb_seq_restoring_div;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[$];

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one division; lat = negedge index of the done pulse (1 = first cycle after accept).
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 16'h5A5A;
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        int nbusy;

`ifdef SEQ_DIV_SIGNED_EN
        vecs.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
        vecs.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        vecs.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
        vecs.push_back('{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0});
        vecs.push_back('{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1});
        vecs.push_back('{16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1});
        vecs.push_back('{16'd9,    16'd3,    16'd3,    16'd0,    1'b0});
`else
        vecs.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        vecs.push_back('{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0});
        vecs.push_back('{16'd3,    16'hFFFF, 16'd0,    16'd3,    1'b0});
        vecs.push_back('{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1});
        vecs.push_back('{16'd9,    16'd3,    16'd3,    16'd0,    1'b0});
        vecs.push_back('{16'd0,    16'd5,    16'd0,    16'd0,    1'b0});
        vecs.push_back('{16'd12345, 16'd123, 16'd100,  16'd45,   1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0});
        vecs.push_back('{16'h8000, 16'd2,    16'h4000, 16'd0,    1'b0});
        vecs.push_back('{16'd7,    16'd8,    16'd0,    16'd7,    1'b0});
`endif

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", {16'd0, quotient}, 32'd0);
        chk("reset remainder", {16'd0, remainder}, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_div(vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("vec%0d latency", i), lat, (vecs[i].b == '0) ? 32'd1 : W + 1);
            chk($sformatf("vec%0d busy cycles", i), bcnt, (vecs[i].b == '0) ? 32'd0 : W);
            chk($sformatf("vec%0d busy at done", i), {31'd0, busy}, 32'd0);
            chk($sformatf("vec%0d quotient", i), {16'd0, quotient}, {16'd0, vecs[i].q});
            chk($sformatf("vec%0d remainder", i), {16'd0, remainder}, {16'd0, vecs[i].r});
            chk($sformatf("vec%0d div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
            @(negedge clk);
            chk($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d quotient held", i), {16'd0, quotient}, {16'd0, vecs[i].q});
        end

        // start pulsed during RUN with different operands must be ignored
        @(negedge clk);
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 5) begin
                dividend = 16'd50; divisor = 16'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                chk("restart latency", c, W + 1);
                chk("restart quotient", {16'd0, quotient}, 32'd14);
                chk("restart remainder", {16'd0, remainder}, 32'd2);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("restart done count", ndone, 32'd1);

        // reset in the middle of RUN aborts with no done
        @(negedge clk);
        dividend = 16'd200; divisor = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort quotient", {16'd0, quotient}, 32'd0);
        chk("abort remainder", {16'd0, remainder}, 32'd0);
        chk("abort div_zero", {31'd0, div_zero}, 32'd0);
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        chk("abort done count", ndone, 32'd0);
        chk("abort busy count", nbusy, 32'd0);
        do_div(16'd9, 16'd3, lat, bcnt);
        chk("post-reset latency", lat, W + 1);
        chk("post-reset quotient", {16'd0, quotient}, 32'd3);
        chk("post-reset remainder", {16'd0, remainder}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
